// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU bench: bus widths, stall LFSR taps
// and the memory-model state encoding.
package cpu_bus_pkg;

  localparam int BUS_W  = 32;
  localparam int BE_W   = 4;
  localparam int LFSR_W = 16;

  // Galois mask for x^16 + x^14 + x^13 + x^11 with a right-shifting register.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE,
    WAIT
  } ram_state_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/avalon_wait_ram_stall_lfsr.sv
// 16-bit Galois LFSR that supplies per-transfer random stall lengths.
// It only moves when a new bus request is accepted, so a run of stalls is
// reproducible from the seed alone.
module stall_lfsr
  import cpu_bus_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  logic [LFSR_W-1:0] state;

  // Load the seed on reset, otherwise step once per accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

  assign value = state[7:0];

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave memory model with programmable wait states, byte-enabled
// writes, a bench preload port and a sticky bus-error flag.
module avalon_wait_ram
  import cpu_bus_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000,
  parameter int              WAIT_CYCLES = 0,
  parameter bit              RAND_MODE   = 1'b0,
  parameter int              MAX_WAIT    = 3,
  parameter logic [15:0]     LFSR_SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BUS_W-1:0]  address,
  input  logic              write,
  input  logic              read,
  output logic              waitrequest,
  input  logic [BUS_W-1:0]  writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [BUS_W-1:0]  readdata,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [BUS_W-1:0]  load_data,
  output logic              bus_error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 16;

  ram_state_t        state;
  ram_state_t        state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  stall_len;
  logic [7:0]        lfsr_value;

  logic              req;
  logic              accept;
  logic              done;

  logic [31:0]       word_off;
  logic              in_range;
  logic              misaligned;
  logic              both_req;
  logic [ADDR_W-1:0] index;

  logic [BUS_W-1:0]  mem [DEPTH];
  logic [BUS_W-1:0]  stored_word;
  logic [BUS_W-1:0]  readdata_q;
  logic              bus_error_q;

  assign req = read | write;

  stall_lfsr #(
    .SEED(LFSR_SEED)
  ) u_stall_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(accept),
    .value  (lfsr_value)
  );

  // Stall length for the transfer being accepted: fixed, or random in 0..MAX_WAIT.
  always_comb begin
    if (RAND_MODE) begin
      stall_len = CNT_W'({1'b0, lfsr_value} % 9'(MAX_WAIT + 1));
    end else begin
      stall_len = CNT_W'(WAIT_CYCLES);
    end
  end

  // Next-state logic; the FSM is frozen while reset or a preload is active.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    done       = 1'b0;
    if (!reset && !load_en) begin
      case (state)
        IDLE: begin
          if (req) begin
            accept = 1'b1;
            if (stall_len == '0) begin
              done = 1'b1;
            end else begin
              state_next = WAIT;
              count_next = stall_len - CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state_next = IDLE;
          end else if (count == '0) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            count_next = count - CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  assign waitrequest = reset | load_en | (req & ~done);

  // Address decode: unsigned wrap makes addresses below the base out of range.
  assign word_off    = (address - BASE_ADDR) >> 2;
  assign in_range    = (word_off < 32'(DEPTH));
  assign index       = word_off[ADDR_W-1:0];
  assign misaligned  = |address[1:0];
  assign both_req    = read & write;
  assign stored_word = in_range ? mem[index] : '0;

  // Memory contents: cleared on reset, preload has priority, then byte-lane writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (done && write && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteenable[b]) begin
          mem[index][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

  // Hold the last completed read and latch any protocol or range error until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      if (done && read && !write) begin
        readdata_q <= stored_word;
      end
      if (done && (!in_range || misaligned || both_req)) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  assign readdata  = (done && read && !write) ? stored_word : readdata_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Bench for avalon_wait_ram. Four instances share one stimulus bus:
//   0: zero wait, 1: three waits, 2: four waits, 3: random waits (MAX_WAIT=3).
// Each test watches the instance whose timing it targets.
module tb_avalon_wait_ram;

  localparam int NDUT    = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        waitreq [NDUT];
  logic [31:0] rdata   [NDUT];
  logic        berr    [NDUT];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_q  [$];
  int          exp_stall_q [$];

  always #5 clk = ~clk;

  avalon_wait_ram #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .waitrequest(waitreq[0]), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata[0]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .bus_error(berr[0]));

  avalon_wait_ram #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .waitrequest(waitreq[1]), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata[1]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .bus_error(berr[1]));

  avalon_wait_ram #(.ADDR_W(8), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .waitrequest(waitreq[2]), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata[2]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .bus_error(berr[2]));

  avalon_wait_ram #(.ADDR_W(8), .RAND_MODE(1'b1), .MAX_WAIT(3), .LFSR_SEED(16'hACE1)) u_rnd (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .waitrequest(waitreq[3]), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata[3]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .bus_error(berr[3]));

  // Drives one transfer from the start of a cycle and holds it until instance k
  // drops waitrequest; returns at the start of the cycle after completion.
  task automatic apply_stimulus(input int k, input logic is_rd, input logic is_wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] be, output int stall,
                                output logic [31:0] seen, output bit timed_out);
    bit finished;
    finished   = 1'b0;
    stall      = -1;
    seen       = '0;
    read       = is_rd;
    write      = is_wr;
    address    = addr;
    writedata  = data;
    byteenable = be;
    load_en    = 1'b0;
    for (int c = 0; c <= TIMEOUT && !finished; c++) begin
      @(negedge clk);
      if (waitreq[k] === 1'b0) begin
        seen     = rdata[k];
        stall    = c;
        finished = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    timed_out = !finished;
  endtask

  task automatic idle_cycle();
    read    = 1'b0;
    write   = 1'b0;
    load_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset   = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    load_en = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    read      = 1'b0;
    write     = 1'b0;
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    read       = 1'b1;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = 4'hF;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (waitreq[k] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_waitreq dut%0d: got %b expected 1", k, waitreq[k]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    read  = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (rdata[k] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_readdata dut%0d: got %h expected 0", k, rdata[k]);
      end
      checks++;
      if (berr[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_bus_error dut%0d: got %b expected 0", k, berr[k]);
      end
      checks++;
      if (waitreq[k] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_waitreq dut%0d: got %b expected 0", k, waitreq[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_preload_read();
    int stall; logic [31:0] seen; bit to; int es; logic [31:0] ed;
    pulse_reset();
    load_en   = 1'b1;
    load_addr = 8'd1;
    load_data = 32'h240ABFC0;
    read      = 1'b1;
    address   = 32'h4;
    @(negedge clk);
    checks++;
    if (waitreq[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_stall: got %b expected 1", waitreq[0]);
    end
    @(posedge clk);
    #1;
    exp_data_q.push_back(32'h240ABFC0);
    exp_stall_q.push_back(0);
    apply_stimulus(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, stall, seen, to);
    ed = exp_data_q.pop_front();
    es = exp_stall_q.pop_front();
    checks++;
    if (to) begin errors++; $display("[TB] FAIL preload_read timeout: no completion in %0d cycles", TIMEOUT); end
    checks++;
    if (stall !== es) begin errors++; $display("[TB] FAIL preload_read stall: got %0d expected %0d", stall, es); end
    checks++;
    if (seen !== ed) begin errors++; $display("[TB] FAIL preload_read data: got %h expected %h", seen, ed); end
    idle_cycle();
    @(negedge clk);
    checks++;
    if (rdata[0] !== 32'h240ABFC0) begin
      errors++;
      $display("[TB] FAIL readdata_hold: got %h expected 240abfc0", rdata[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_write();
    int stall; logic [31:0] seen; bit to; int es; logic [31:0] ed;
    pulse_reset();
    exp_stall_q.push_back(3);
    apply_stimulus(1, 1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101, stall, seen, to);
    es = exp_stall_q.pop_front();
    checks++;
    if (to || stall !== es) begin errors++; $display("[TB] FAIL byte_write stall: got %0d expected %0d", stall, es); end
    exp_stall_q.push_back(3);
    apply_stimulus(1, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, stall, seen, to);
    es = exp_stall_q.pop_front();
    checks++;
    if (to || stall !== es) begin errors++; $display("[TB] FAIL zero_be_write stall: got %0d expected %0d", stall, es); end
    exp_stall_q.push_back(3);
    exp_data_q.push_back(32'h00220044);
    apply_stimulus(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, stall, seen, to);
    es = exp_stall_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++;
    if (to || stall !== es) begin errors++; $display("[TB] FAIL byte_read stall: got %0d expected %0d", stall, es); end
    checks++;
    if (seen !== ed) begin errors++; $display("[TB] FAIL byte_read data: got %h expected %h", seen, ed); end
    checks++;
    if (berr[1] !== 1'b0) begin errors++; $display("[TB] FAIL byte_write bus_error: got %b expected 0", berr[1]); end
    idle_cycle();
  endtask

  task automatic test_abort();
    int stall; logic [31:0] seen; bit to; int es; logic [31:0] ed;
    pulse_reset();
    read    = 1'b1;
    address = 32'h8;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (waitreq[2] !== 1'b1) begin errors++; $display("[TB] FAIL abort_stall cycle %0d: got %b expected 1", c, waitreq[2]); end
      @(posedge clk);
      #1;
    end
    read = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata[2] !== 32'h0 || waitreq[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_completion: got data %h wait %b expected 0/0", rdata[2], waitreq[2]);
    end
    @(posedge clk);
    #1;
    exp_stall_q.push_back(4);
    apply_stimulus(2, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, stall, seen, to);
    es = exp_stall_q.pop_front();
    checks++;
    if (to || stall !== es) begin errors++; $display("[TB] FAIL post_abort_write stall: got %0d expected %0d", stall, es); end
    exp_stall_q.push_back(4);
    exp_data_q.push_back(32'hA5A5A5A5);
    apply_stimulus(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, stall, seen, to);
    es = exp_stall_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++;
    if (to || stall !== es) begin errors++; $display("[TB] FAIL post_abort_read stall: got %0d expected %0d", stall, es); end
    checks++;
    if (seen !== ed) begin errors++; $display("[TB] FAIL post_abort_read data: got %h expected %h", seen, ed); end
    idle_cycle();
  endtask

  task automatic test_random_back_to_back();
    int stall; logic [31:0] seen; bit to; int es; logic [31:0] ed;
    logic [15:0] model;
    logic [7:0]  low;
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      preload(8'(i), 32'hC0DE0000 | (32'(i) * 32'h111));
    end
    model = 16'hACE1;
    for (int n = 0; n < 50; n++) begin
      low = model[7:0];
      exp_stall_q.push_back(int'(low) % 4);
      exp_data_q.push_back(32'hC0DE0000 | (32'(n % 16) * 32'h111));
      model = model[0] ? ((model >> 1) ^ 16'hB400) : (model >> 1);
      apply_stimulus(3, 1'b1, 1'b0, 32'((n % 16) * 4), 32'h0, 4'hF, stall, seen, to);
      es = exp_stall_q.pop_front();
      ed = exp_data_q.pop_front();
      checks++;
      if (to) begin errors++; $display("[TB] FAIL rand_read %0d timeout", n); end
      checks++;
      if (stall < 0 || stall > 3) begin errors++; $display("[TB] FAIL rand_range %0d: got %0d expected 0..3", n, stall); end
      checks++;
      if (stall !== es) begin errors++; $display("[TB] FAIL rand_stall %0d: got %0d expected %0d", n, stall, es); end
      checks++;
      if (seen !== ed) begin errors++; $display("[TB] FAIL rand_data %0d: got %h expected %h", n, seen, ed); end
    end
    idle_cycle();
    checks++;
    if (berr[3] !== 1'b0) begin errors++; $display("[TB] FAIL rand_bus_error: got %b expected 0", berr[3]); end
  endtask

  task automatic test_errors();
    int stall; logic [31:0] seen; bit to; logic [31:0] ed;
    pulse_reset();
    preload(8'd0, 32'hDEADBEEF);
    checks++;
    if (berr[0] !== 1'b0) begin errors++; $display("[TB] FAIL err_initial: got %b expected 0", berr[0]); end
    exp_data_q.push_back(32'h0);
    apply_stimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, stall, seen, to);
    ed = exp_data_q.pop_front();
    checks++;
    if (to || seen !== ed) begin errors++; $display("[TB] FAIL oor_read data: got %h expected %h", seen, ed); end
    checks++;
    if (berr[0] !== 1'b1) begin errors++; $display("[TB] FAIL oor_read bus_error: got %b expected 1", berr[0]); end
    apply_stimulus(0, 1'b0, 1'b1, 32'h400, 32'h0, 4'hF, stall, seen, to);
    exp_data_q.push_back(32'hDEADBEEF);
    apply_stimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, stall, seen, to);
    ed = exp_data_q.pop_front();
    checks++;
    if (to || seen !== ed) begin errors++; $display("[TB] FAIL oor_write_ignored: got %h expected %h", seen, ed); end
    checks++;
    if (berr[0] !== 1'b1) begin errors++; $display("[TB] FAIL bus_error_sticky: got %b expected 1", berr[0]); end
    pulse_reset();
    checks++;
    if (berr[0] !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", berr[0]); end
    preload(8'd1, 32'h12345678);
    exp_data_q.push_back(32'h12345678);
    apply_stimulus(0, 1'b1, 1'b0, 32'h6, 32'h0, 4'hF, stall, seen, to);
    ed = exp_data_q.pop_front();
    checks++;
    if (to || seen !== ed) begin errors++; $display("[TB] FAIL misaligned_read data: got %h expected %h", seen, ed); end
    checks++;
    if (berr[0] !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_bus_error: got %b expected 1", berr[0]); end
    pulse_reset();
    apply_stimulus(0, 1'b1, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, stall, seen, to);
    checks++;
    if (to || seen !== 32'h0) begin errors++; $display("[TB] FAIL rw_readdata: got %h expected 0", seen); end
    checks++;
    if (berr[0] !== 1'b1) begin errors++; $display("[TB] FAIL rw_bus_error: got %b expected 1", berr[0]); end
    exp_data_q.push_back(32'h5A5A5A5A);
    apply_stimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, stall, seen, to);
    ed = exp_data_q.pop_front();
    checks++;
    if (to || seen !== ed) begin errors++; $display("[TB] FAIL rw_as_write data: got %h expected %h", seen, ed); end
    idle_cycle();
  endtask

  task automatic test_reset_load();
    int stall; logic [31:0] seen; bit to; int es; logic [31:0] ed;
    pulse_reset();
    preload(8'd2, 32'h77777777);
    read    = 1'b1;
    address = 32'h4;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (waitreq[2] !== 1'b1) begin errors++; $display("[TB] FAIL mid_wait_reset waitreq: got %b expected 1", waitreq[2]); end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    load_en   = 1'b1;
    load_addr = 8'd1;
    load_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (waitreq[2] !== 1'b1) begin errors++; $display("[TB] FAIL load_hold cycle %0d: got %b expected 1", c, waitreq[2]); end
      @(posedge clk);
      #1;
    end
    exp_stall_q.push_back(4);
    exp_data_q.push_back(32'hCAFEF00D);
    apply_stimulus(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, stall, seen, to);
    es = exp_stall_q.pop_front();
    ed = exp_data_q.pop_front();
    checks++;
    if (to || stall !== es) begin errors++; $display("[TB] FAIL after_load stall: got %0d expected %0d", stall, es); end
    checks++;
    if (seen !== ed) begin errors++; $display("[TB] FAIL after_load data: got %h expected %h", seen, ed); end
    exp_data_q.push_back(32'h0);
    apply_stimulus(2, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, stall, seen, to);
    ed = exp_data_q.pop_front();
    checks++;
    if (to || seen !== ed) begin errors++; $display("[TB] FAIL memory_cleared: got %h expected %h", seen, ed); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_byte_write();
    test_abort();
    test_random_back_to_back();
    test_errors();
    test_reset_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/avalon_wait_ram.md
Name: avalon_wait_ram

Overview:
Parametrised Avalon-MM slave memory model for CPU benches. It succeeds the fixed zero-wait instruction RAM with configurable depth, base address, byte-enabled writes, and programmable wait states (fixed or LFSR-random), so the top_level_cpu waitrequest stall paths get exercised. It also provides a bench preload port and a sticky bus-error flag. It sits between top_level_cpu and the testbench stimulus.

Parameters:
ADDR_W, 8, word-index width; DEPTH = 2**ADDR_W words
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
WAIT_CYCLES, 0, stall cycles per transfer in fixed mode
RAND_MODE, 0, 1 = per-transfer stall drawn from LFSR
MAX_WAIT, 3, upper bound on random stall (RAND_MODE=1)
LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
address  in  32  Avalon byte address
write  in  1  write request
read  in  1  read request
waitrequest  out  1  stall; transfer completes in the cycle it is low with a request present
writedata  in  32  write data
byteenable  in  4  lane enables; bit i enables bits 8i+7:8i
readdata  out  32  read data
load_en  in  1  bench preload strobe
load_addr  in  ADDR_W  preload word index
load_data  in  32  preload word, written whole
bus_error  out  1  sticky protocol/range error

Behaviour:
- Reset (synchronous): FSM->IDLE, counter=0, LFSR=LFSR_SEED, memory all zero, readdata=0, bus_error=0. waitrequest=1 in any cycle with reset high.
- req = read|write. Stall length L per transfer: WAIT_CYCLES if RAND_MODE=0, else LFSR[7:0] mod (MAX_WAIT+1).
- L is sampled when req is first seen in IDLE. LFSR (x^16+x^14+x^13+x^11) advances once per accepted request.
- Timing: request first present in cycle n gives waitrequest=1 for cycles n..n+L-1 and waitrequest=0 in cycle n+L (completion). L=0 completes in cycle n.
- FSM IDLE -> WAIT (L>0, counter=L-1) -> completion when counter==0 -> IDLE.
- Back-to-back requests: the next transfer starts in the cycle after completion, with a fresh L.
- Abort: if req drops while in WAIT, go to IDLE with no memory effect. The LFSR is not rewound.
- waitrequest combinational: reset | load_en | (req & ~done).
- Word index = (address - BASE_ADDR) >> 2. address[1:0] is ignored for indexing; a non-zero value sets bus_error.
- Out of range (index >= DEPTH, or address < BASE_ADDR): completes with normal timing, read returns 0, write is ignored, bus_error is set.
- Write: at the rising edge ending the completion cycle, update only the byteenable lanes. byteenable=0 writes nothing and raises no error.
- Read: readdata is combinational in the completion cycle, equal to the full stored word (the master masks). byteenable is ignored for reads. readdata holds the last completed read value otherwise.
- read & write together: treated as write, bus_error set.
- load_en: word written at the edge. Bus requests are stalled (waitrequest=1) and the FSM/counter are frozen while load_en=1.
- Same-cycle load and bus write to the same word cannot occur, because the bus is stalled.
- bus_error stays set until reset.
- Width rules: address arithmetic is 32-bit unsigned; the subtraction wraps, so an address below base reads as out of range.

Decomposition:
- Shared package cpu_bus_pkg: BUS_W=32, BE_W=4, LFSR polynomial taps, typedef enum {IDLE, WAIT} ram_state_t. The CPU bench reuses these.
- One sub-module: stall_lfsr, 16-bit Galois LFSR with seed, advance enable, and 8-bit output.
- Memory array, FSM and decode stay in avalon_wait_ram.

Test Plan:
- WAIT_CYCLES=0: preload word 1 = 32'h240ABFC0; read address 4 -> waitrequest 0 in cycle n, readdata=32'h240ABFC0.
- WAIT_CYCLES=3: write 32'h11223344 at address 8 with byteenable 4'b0101 over a zero word -> waitrequest high for exactly 3 cycles; a later read returns 32'h00220044.
- Abort: WAIT_CYCLES=4, drop read after 2 cycles, then write address 8 -> no completion on the aborted read; the following write takes a full 4-cycle stall.
- RAND_MODE=1, MAX_WAIT=3, 50 back-to-back reads -> every stall is in 0..3, each stall length matches the reference LFSR model, and all data is correct.
- Errors: read address 32'h400 (ADDR_W=8) -> readdata 0, bus_error=1. Reset clears the flag; a read at address 6 sets it again.
- Reset mid-WAIT, then load_en during a pending read -> FSM returns to IDLE with memory zeroed; while load_en=1 waitrequest stays high, and the read completes L cycles after load_en falls.
